// File: rtl/nrzi_unstuff_deserializer_pkg.sv
// Shared types and USB line constants for the receive bit layer.
// Provides the receive FSM state type and default stuffing/idle parameters.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RUN,
        RX_ERROR
    } rx_state_t;

    localparam int   USB_STUFF_LEN = 6;
    localparam logic USB_IDLE_J    = 1'b1;

endpackage

// File: rtl/nrzi_unstuff_deserializer_if.sv
// Bus between line sampler / packet decoder and the receive bit layer.
// Ports: decode_en, bit_strobe, rx_bit, se0 (to stage); data_out, data_valid,
//        eop, partial_err, stuff_err, busy (from stage).
interface nrzi_unstuff_deserializer_if #(
    parameter int DATA_W = 8
);

    logic              decode_en;
    logic              bit_strobe;
    logic              rx_bit;
    logic              se0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              eop;
    logic              partial_err;
    logic              stuff_err;
    logic              busy;

    modport master (
        output decode_en, bit_strobe, rx_bit, se0,
        input  data_out, data_valid, eop, partial_err, stuff_err, busy
    );

    modport slave (
        input  decode_en, bit_strobe, rx_bit, se0,
        output data_out, data_valid, eop, partial_err, stuff_err, busy
    );

endinterface

// File: rtl/nrzi_unstuff_deserializer_unstuffer.sv
// NRZI decode and run-length tracking of decoded 1s for bit unstuffing.
// Ports: clk, RST, clr (reload idle level / clear run), step (accepted strobe),
//        rx_bit (line level); dec, drop (stuffed bit), err (stuff violation).
import usb_rx_pkg::*;

module nrzi_bit_unstuffer #(
    parameter int   STUFF_LEN  = USB_STUFF_LEN,
    parameter logic IDLE_LEVEL = USB_IDLE_J
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic step,
    input  logic rx_bit,
    output logic dec,
    output logic drop,
    output logic err
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [OW-1:0] LIM = OW'(STUFF_LEN);

    logic          prev_lvl;
    logic [OW-1:0] ones_cnt;
    logic          at_lim;

    // No transition on the line decodes as a 1.
    assign dec    = (rx_bit == prev_lvl);
    assign at_lim = (ones_cnt == LIM);
    assign drop   = at_lim & ~dec;
    assign err    = at_lim & dec;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            prev_lvl <= IDLE_LEVEL;
            ones_cnt <= '0;
        end else if (clr) begin
            prev_lvl <= IDLE_LEVEL;
            ones_cnt <= '0;
        end else if (step) begin
            prev_lvl <= rx_bit;
            // On a violation the count holds; the FSM leaves RUN anyway.
            if (drop)
                ones_cnt <= '0;
            else if (!err)
                ones_cnt <= dec ? ones_cnt + OW'(1) : '0;
        end
    end

endmodule

// File: rtl/nrzi_unstuff_deserializer.sv
// USB receive bit layer: NRZI decode, unstuffing, LSB-first word assembly, EOP.
// Ports: clk, RST (async, active high), bus (slave modport of the rx interface).
import usb_rx_pkg::*;

module nrzi_unstuff_deserializer #(
    parameter int   DATA_W     = 8,
    parameter int   STUFF_LEN  = USB_STUFF_LEN,
    parameter logic IDLE_LEVEL = USB_IDLE_J
) (
    input logic                          clk,
    input logic                          RST,
    nrzi_unstuff_deserializer_if.slave   bus
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    rx_state_t         state, state_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] word, word_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              valid_q, valid_nxt;
    logic              eop_q, eop_nxt;
    logic              part_q, part_nxt;
    logic              serr_q, serr_nxt;

    logic dec, drop, err;
    logic clr, step;

    // Decoder history is reloaded whenever we are not actively receiving.
    assign clr  = (state != RX_RUN) | ~bus.decode_en;
    assign step = (state == RX_RUN) & bus.decode_en & bus.bit_strobe;

    nrzi_bit_unstuffer #(
        .STUFF_LEN  (STUFF_LEN),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_unstuff (
        .clk    (clk),
        .RST    (RST),
        .clr    (clr),
        .step   (step),
        .rx_bit (bus.rx_bit),
        .dec    (dec),
        .drop   (drop),
        .err    (err)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            word    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            part_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            word    <= word_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            eop_q   <= eop_nxt;
            part_q  <= part_nxt;
            serr_q  <= serr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        word_nxt    = word;
        data_nxt    = data_q;
        valid_nxt   = 1'b0;
        eop_nxt     = 1'b0;
        part_nxt    = 1'b0;
        serr_nxt    = 1'b0;
        if (!bus.decode_en) begin
            state_nxt   = RX_IDLE;
            bit_cnt_nxt = '0;
        end else begin
            unique case (state)
                RX_IDLE: begin
                    state_nxt   = RX_RUN;
                    bit_cnt_nxt = '0;
                end
                RX_RUN: begin
                    if (bus.bit_strobe) begin
                        if (bus.se0) begin
                            eop_nxt     = 1'b1;
                            part_nxt    = (bit_cnt != '0);
                            bit_cnt_nxt = '0;
                            state_nxt   = RX_IDLE;
                        end else if (drop) begin
                            bit_cnt_nxt = bit_cnt;
                        end else if (err) begin
                            serr_nxt  = 1'b1;
                            state_nxt = RX_ERROR;
                        end else begin
                            word_nxt[bit_cnt] = dec;
                            if (bit_cnt == LAST) begin
                                data_nxt    = word_nxt;
                                valid_nxt   = 1'b1;
                                bit_cnt_nxt = '0;
                            end else begin
                                bit_cnt_nxt = bit_cnt + BW'(1);
                            end
                        end
                    end
                end
                RX_ERROR: begin
                    state_nxt = RX_ERROR;
                end
                default: begin
                    state_nxt = RX_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.eop         = eop_q;
    assign bus.partial_err = part_q;
    assign bus.stuff_err   = serr_q;
    assign bus.busy        = (state == RX_RUN);

endmodule

// File: tb/tb_nrzi_unstuff_deserializer.sv
// Testbench for the USB receive bit layer.
// Encodes bytes (stuff + NRZI) at the transmitter level and checks decoded output.
module tb_nrzi_unstuff_deserializer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    nrzi_unstuff_deserializer_if #(.DATA_W(DW)) bus ();

    nrzi_unstuff_deserializer #(
        .DATA_W     (DW),
        .STUFF_LEN  (6),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic line;
    int   ones;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int   n_eop, n_part, n_serr;
    logic s_valid, s_eop, s_part, s_serr, s_busy;

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        n_eop  = 0;
        n_part = 0;
        n_serr = 0;
    endtask

    // One strobe; outputs sampled 1 time unit after the capturing edge.
    task automatic strobe(input logic lvl, input logic s0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        bus.bit_strobe = 1'b1;
        bus.rx_bit     = lvl;
        bus.se0        = s0;
        @(posedge clk);
        #1;
        s_valid = bus.data_valid;
        s_eop   = bus.eop;
        s_part  = bus.partial_err;
        s_serr  = bus.stuff_err;
        s_busy  = bus.busy;
        if (s_valid) got_q.push_back(bus.data_out);
        if (s_eop)   n_eop++;
        if (s_part)  n_part++;
        if (s_serr)  n_serr++;
        bus.bit_strobe = 1'b0;
        bus.se0        = 1'b0;
    endtask

    // Transmit one decoded bit: a 0 toggles the line, a 1 keeps it.
    task automatic send_dec(input logic b);
        if (!b) line = ~line;
        strobe(line, 1'b0);
    endtask

    // Transmitter-side bit stuffing: a 0 is inserted after every six 1s.
    task automatic send_byte(input logic [DW-1:0] v);
        for (int i = 0; i < DW; i++) begin
            send_dec(v[i]);
            if (v[i]) begin
                ones++;
                if (ones == 6) begin
                    send_dec(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        exp_q.push_back(v);
    endtask

    task automatic send_eop();
        strobe(1'b0, 1'b1);
        line = 1'b1;
        ones = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic open_rx();
        @(negedge clk);
        bus.decode_en = 1'b1;
        line = 1'b1;
        ones = 0;
        repeat (2) @(negedge clk);
        clear_obs();
    endtask

    task automatic close_rx();
        @(negedge clk);
        bus.decode_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.decode_en  = 1'b0;
        bus.bit_strobe = 1'b0;
        bus.rx_bit     = 1'b1;
        bus.se0        = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.data_out !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=00", bus.data_out);
        end
        checks++;
        if ({bus.data_valid, bus.eop, bus.partial_err, bus.stuff_err, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                {bus.data_valid, bus.eop, bus.partial_err, bus.stuff_err, bus.busy});
        end
        RST = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_a5();
        open_rx();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL a5_busy got=%b exp=1", bus.busy);
        end
        send_byte(8'hA5);
        checks++;
        if (s_valid !== 1'b1) begin
            errors++;
            $display("FAIL a5_latency got=%b exp=1", s_valid);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL a5_word got_n=%0d got=%h exp=a5", got_q.size(),
                got_q.size() > 0 ? got_q[0] : 8'h00);
        end
        send_eop();
        checks++;
        if (n_eop != 1 || n_part != 0) begin
            errors++;
            $display("FAIL a5_eop got eop=%0d part=%0d exp 1/0", n_eop, n_part);
        end
    endtask

    task automatic test_stuffed();
        open_rx();
        send_byte(8'hBF);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hBF || n_serr != 0) begin
            errors++;
            $display("FAIL stuffed_word got_n=%0d got=%h serr=%0d exp=bf serr=0",
                got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, n_serr);
        end
        send_eop();
    endtask

    task automatic test_stuff_err();
        open_rx();
        for (int i = 0; i < 7; i++) send_dec(1'b1);
        checks++;
        if (s_serr !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL stuff_err_pulse got serr=%b busy=%b exp 1/0", s_serr, s_busy);
        end
        for (int i = 0; i < 12; i++) send_dec(i[0]);
        checks++;
        if (got_q.size() != 0 || n_serr != 1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL stuff_err_hold got words=%0d serr=%0d busy=%b exp 0/1/0",
                got_q.size(), n_serr, s_busy);
        end
        close_rx();
        open_rx();
        send_byte(8'h3C);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
            errors++;
            $display("FAIL stuff_err_recover got_n=%0d exp word 3c", got_q.size());
        end
        send_eop();
    endtask

    task automatic test_partial();
        open_rx();
        for (int i = 0; i < 3; i++) send_dec(1'($urandom_range(0, 1)));
        send_eop();
        checks++;
        if (s_eop !== 1'b1 || s_part !== 1'b1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL partial_eop got eop=%b part=%b words=%0d exp 1/1/0",
                s_eop, s_part, got_q.size());
        end
        send_byte(8'($urandom));
        send_eop();
        checks++;
        if (s_eop !== 1'b1 || s_part !== 1'b0 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL full_eop got eop=%b part=%b words=%0d exp 1/0/1",
                s_eop, s_part, got_q.size());
        end
    endtask

    task automatic test_boundary();
        open_rx();
        send_byte(8'hFC);
        send_byte(8'h0F);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'hFC || got_q[1] !== 8'h0F || n_serr != 0) begin
            errors++;
            $display("FAIL boundary got_n=%0d serr=%0d exp fc,0f serr=0", got_q.size(), n_serr);
        end
        send_eop();
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            open_rx();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                if ($urandom_range(0, 3) == 0) send_byte(8'hFF);
                else send_byte(8'($urandom));
            end
            send_eop();
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count pkt=%0d got=%0d exp=%0d", p, got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand_word pkt=%0d idx=%0d got=%h exp=%h",
                            p, i, got_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (n_eop != 1 || n_part != 0 || n_serr != 0) begin
                errors++;
                $display("FAIL rand_flags pkt=%0d eop=%0d part=%0d serr=%0d exp 1/0/0",
                    p, n_eop, n_part, n_serr);
            end
        end
    endtask

    task automatic test_abort();
        open_rx();
        for (int i = 0; i < 4; i++) send_dec(1'($urandom_range(0, 1)));
        @(negedge clk);
        RST = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== '0 || bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got data=%h busy=%b valid=%b exp 00/0/0",
                bus.data_out, bus.busy, bus.data_valid);
        end
        bus.decode_en = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        open_rx();
        send_byte(8'h5A);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            errors++;
            $display("FAIL rst_recover got_n=%0d exp word 5a", got_q.size());
        end
        send_eop();
        open_rx();
        for (int i = 0; i < 5; i++) send_dec(1'b0);
        close_rx();
        strobe(1'b0, 1'b1);
        checks++;
        if (s_busy !== 1'b0 || n_eop != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL en_drop got busy=%b eop=%0d words=%0d exp 0/0/0",
                s_busy, n_eop, got_q.size());
        end
        open_rx();
        send_byte(8'hC3);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin
            errors++;
            $display("FAIL en_recover got_n=%0d exp word c3", got_q.size());
        end
        send_eop();
    endtask

    initial begin
        test_reset();
        test_a5();
        test_stuffed();
        test_stuff_err();
        test_partial();
        test_boundary();
        test_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
